// File: rtl/yv_lvds_pkg.sv
`default_nettype none
// ============================================================================
// yv_lvds_pkg : shared constants and types for the 7:1 LVDS transmit bank
// Revision    : 1.0
// ============================================================================
package yv_lvds_pkg;

    localparam int                   SYM_BITS    = 7;
    localparam logic [SYM_BITS-1:0]  CLK_PATTERN = 7'b1100011;
    localparam logic [SYM_BITS-1:0]  IDLE_SYM    = 7'b0000000;
    localparam logic [SYM_BITS-1:0]  WALK_SEED   = 7'b1000000;
    localparam logic [2:0]           LAST_PHASE  = 3'd6;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_IDLE   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    function automatic logic [SYM_BITS-1:0] walk_sym(input logic [2:0] idx);
        return WALK_SEED >> idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/yv_obufds_bank.sv
`default_nettype none
// ============================================================================
// yv_obufds_bank : WIDTH single-ended to differential output buffers
// Revision       : 1.0
// ============================================================================
module yv_obufds_bank #(
    parameter int    WIDTH      = 1,
    parameter string IOSTANDARD = "LVDS_25"
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pad_p,
    output logic [WIDTH-1:0] pad_n
);

    if (IOSTANDARD == "") begin : g_iostd_check
        $error("yv_obufds_bank: IOSTANDARD must name a differential standard");
    end

    // Behavioural stand-in for one OBUFDS cell per lane; the vendor
    // primitive drops in here with IOSTANDARD passed straight through.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign pad_p[i] = din[i];
        assign pad_n[i] = ~din[i];
    end

endmodule
`default_nettype wire

// File: rtl/yv_lvds_tx_serializer.sv
`default_nettype none
// ============================================================================
// yv_lvds_tx_serializer : multi-lane 7:1 LVDS transmitter with forwarded clock
// Revision              : 1.0
// ============================================================================
module yv_lvds_tx_serializer
    import yv_lvds_pkg::*;
#(
    parameter int    NUM_LANES  = 4,
    parameter string IOSTANDARD = "LVDS_25"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES*SYM_BITS-1:0] tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [1:0]                    mode,
    input  logic [NUM_LANES-1:0]          lane_invert,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic                          sym_strobe,
    output logic [NUM_LANES-1:0]          ser_p,
    output logic [NUM_LANES-1:0]          ser_n,
    output logic                          clk_p,
    output logic                          clk_n
);

    localparam int c_WORD_W = NUM_LANES * SYM_BITS;

    logic [2:0]          r_phase;
    logic                r_started;
    logic                r_full;
    logic [c_WORD_W-1:0] r_hold;
    logic                r_underrun;
    logic [2:0]          r_wc;
    logic                r_walk_active;
    logic [SYM_BITS-1:0] r_sr [NUM_LANES];
    logic [SYM_BITS-1:0] r_clk_sr;

    logic                w_load;
    logic                w_accept;
    logic                w_normal;
    logic                w_walk;
    logic                w_consume;
    logic                w_underrun_set;
    logic [2:0]          w_wc_eff;
    logic [SYM_BITS-1:0] w_sym [NUM_LANES];
    logic [NUM_LANES:0]  w_lane_bits;
    logic [NUM_LANES:0]  w_pad_p;
    logic [NUM_LANES:0]  w_pad_n;

    assign w_load         = (r_phase == LAST_PHASE);
    assign tx_ready       = !r_full && !rst;
    assign w_accept       = tx_valid && tx_ready;
    assign w_walk         = (mode_e'(mode) == MODE_WALK);
    assign w_normal       = (mode_e'(mode) == MODE_NORMAL) || (mode_e'(mode) == MODE_RSVD);
    assign w_consume      = w_load && w_normal && r_full;
    assign w_underrun_set = w_load && w_normal && !r_full;
    // The walking index restarts whenever the previous load was not a walk load.
    assign w_wc_eff       = r_walk_active ? r_wc : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= 3'd0;
            r_started <= 1'b0;
        end else begin
            r_phase <= w_load ? 3'd0 : r_phase + 3'd1;
            if (w_load) begin
                r_started <= 1'b1;
            end
        end
    end

    assign sym_strobe = r_started && (r_phase == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (w_consume) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wc          <= 3'd0;
            r_walk_active <= 1'b0;
        end else if (w_load) begin
            if (w_walk) begin
                r_wc          <= (w_wc_eff == LAST_PHASE) ? 3'd0 : w_wc_eff + 3'd1;
                r_walk_active <= 1'b1;
            end else begin
                r_wc          <= 3'd0;
                r_walk_active <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            w_sym[k] = IDLE_SYM;
            case (mode_e'(mode))
                MODE_WALK: w_sym[k] = walk_sym(w_wc_eff);
                MODE_IDLE: w_sym[k] = IDLE_SYM;
                default: begin
                    if (r_full) begin
                        w_sym[k] = r_hold[k*SYM_BITS +: SYM_BITS];
                    end
                end
            endcase
            w_sym[k] = w_sym[k] ^ {SYM_BITS{lane_invert[k]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_sr[k] <= '0;
            end
            r_clk_sr <= '0;
        end else if (w_load) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_sr[k] <= w_sym[k];
            end
            r_clk_sr <= CLK_PATTERN;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_sr[k] <= {r_sr[k][SYM_BITS-2:0], 1'b0};
            end
            r_clk_sr <= {r_clk_sr[SYM_BITS-2:0], 1'b0};
        end
    end

    always_comb begin
        w_lane_bits = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_lane_bits[k] = r_sr[k][SYM_BITS-1];
        end
        w_lane_bits[NUM_LANES] = r_clk_sr[SYM_BITS-1];
    end

    // Clock lane rides on the top buffer so all lanes share one bank.
    yv_obufds_bank #(
        .WIDTH      (NUM_LANES + 1),
        .IOSTANDARD (IOSTANDARD)
    ) u_obufds_bank (
        .din   (w_lane_bits),
        .pad_p (w_pad_p),
        .pad_n (w_pad_n)
    );

    assign ser_p = w_pad_p[NUM_LANES-1:0];
    assign ser_n = w_pad_n[NUM_LANES-1:0];
    assign clk_p = w_pad_p[NUM_LANES];
    assign clk_n = w_pad_n[NUM_LANES];

endmodule
`default_nettype wire

// File: tb/tb_yv_lvds_tx_serializer.sv
`default_nettype none
// ============================================================================
// tb_yv_lvds_tx_serializer : scoreboard bench for the 7:1 LVDS transmitter
// Revision                 : 1.0
// ============================================================================
module tb_yv_lvds_tx_serializer;

    localparam int NL = 4;
    localparam int W  = NL * 7;

    localparam logic [1:0] M_NORM = 2'd0;
    localparam logic [1:0] M_IDLE = 2'd1;
    localparam logic [1:0] M_WALK = 2'd2;
    localparam logic [1:0] M_RSVD = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [1:0]    mode = M_IDLE;
    logic [NL-1:0] lane_invert = '0;
    logic          underrun;
    logic          underrun_clr = 1'b0;
    logic          sym_strobe;
    logic [NL-1:0] ser_p;
    logic [NL-1:0] ser_n;
    logic          clk_p;
    logic          clk_n;

    always #5 clk = ~clk;

    yv_lvds_tx_serializer #(
        .NUM_LANES  (NL),
        .IOSTANDARD ("LVDS_25")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mode         (mode),
        .lane_invert  (lane_invert),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .sym_strobe   (sym_strobe),
        .ser_p        (ser_p),
        .ser_n        (ser_n),
        .clk_p        (clk_p),
        .clk_n        (clk_n)
    );

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: captures 7 bits per lane starting at each strobe, then scores.
    int           cnt = -1;
    logic [W-1:0] cap;
    logic [6:0]   clk_cap;
    bit           diff_bad = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cnt      = -1;
            diff_bad = 1'b0;
        end else begin
            if (sym_strobe) begin
                if (cnt != -1) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_mid_symbol actual_bit_index=%0d required=none", cnt);
                end
                cnt = 0;
            end
            if (cnt >= 0) begin
                for (int k = 0; k < NL; k++) begin
                    cap[k*7 +: 7] = {cap[k*7 +: 6], ser_p[k]};
                end
                clk_cap = {clk_cap[5:0], clk_p};
                if (ser_n !== ~ser_p || clk_n !== ~clk_p) diff_bad = 1'b1;
                cnt++;
                if (cnt == 7) begin
                    cnt = -1;
                    if (mon_en) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sym_unexpected actual=%0h required=no_symbol", cap);
                        end else begin
                            chk("lane_symbols", cap, exp_q.pop_front());
                        end
                        chk("clk_pattern", clk_cap, 7'b1100011);
                        chk("diff_complement", diff_bad, 1'b0);
                        diff_bad = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_strobe && n < 20);
        chk("strobe_seen", sym_strobe, 1'b1);
    endtask

    // Configure the next load, push its expected lane word, wait for it to go out.
    task automatic sym(input logic [1:0] m, input bit v, input logic [W-1:0] d,
                       input logic [NL-1:0] inv, input logic [W-1:0] e, input int exp_n);
        int n;
        mode        = m;
        lane_invert = inv;
        exp_q.push_back(e);
        if (v) begin
            tx_valid = 1'b1;
            tx_data  = d;
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
        wait_strobe(n);
        chk("sym_period", n, exp_n);
    endtask

    task automatic check_reset();
        chk("rst_ser_p", ser_p, '0);
        chk("rst_ser_n", ser_n, {NL{1'b1}});
        chk("rst_clk_p", clk_p, 1'b0);
        chk("rst_clk_n", clk_n, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_strobe", sym_strobe, 1'b0);
    endtask

    logic [W-1:0] w1, w2, w3, w4, wh;
    logic [6:0]   ws;

    initial begin
        w1 = {7'h7E, 7'h33, 7'h0F, 7'h55};
        w2 = {7'h01, 7'h40, 7'h2A, 7'h7F};
        w3 = {7'h12, 7'h6C, 7'h00, 7'h3C};
        w4 = {7'h5A, 7'h03, 7'h60, 7'h18};
        wh = {7'h11, 7'h22, 7'h33, 7'h44};

        repeat (4) @(negedge clk);
        check_reset();
        rst = 1'b0;
        #1 chk("ready_after_rst", tx_ready, 1'b1);
        sym(M_IDLE, 0, '0, '0, '0, 7);
        sym(M_IDLE, 0, '0, '0, '0, 7);

        sym(M_NORM, 1, w1, '0, w1, 7);
        sym(M_NORM, 1, w2, '0, w2, 7);
        sym(M_NORM, 1, w3, '0, w3, 7);
        chk("no_underrun", underrun, 1'b0);

        sym(M_NORM, 0, '0, '0, '0, 7);
        chk("underrun_set", underrun, 1'b1);
        underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        chk("underrun_cleared", underrun, 1'b0);
        sym(M_NORM, 1, w4, '0, w4, 6);

        underrun_clr = 1'b1;
        sym(M_NORM, 0, '0, '0, '0, 7);
        chk("underrun_set_wins", underrun, 1'b1);
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        chk("underrun_cleared2", underrun, 1'b0);

        sym(M_NORM, 1, w1, 4'b0010, {7'h7E, 7'h33, 7'h70, 7'h55}, 6);
        sym(M_NORM, 1, w2, 4'b1001, {7'h7E, 7'h40, 7'h2A, 7'h00}, 7);

        sym(M_WALK, 1, wh, '0, {4{7'h40}}, 7);
        chk("walk_hold_full", tx_ready, 1'b0);
        for (int i = 1; i < 8; i++) begin
            ws = 7'h40 >> (i % 7);
            sym(M_WALK, 0, '0, '0, {4{ws}}, 7);
            chk("walk_hold_full", tx_ready, 1'b0);
        end
        sym(M_NORM, 0, '0, '0, wh, 7);
        chk("walk_no_underrun", underrun, 1'b0);
        chk("hold_drained", tx_ready, 1'b1);

        sym(M_RSVD, 1, w3, '0, w3, 7);

        mode     = M_NORM;
        tx_valid = 1'b1;
        tx_data  = w2;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("hold_full_before_rst", tx_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst2", tx_ready, 1'b1);
        sym(M_IDLE, 0, '0, '0, '0, 7);
        sym(M_NORM, 1, w1, '0, w1, 7);
        sym(M_IDLE, 0, '0, '0, '0, 7);

        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
